// File: rtl/alt_vipcts131_fifo_read_stream.sv
// rtl/alt_vipcts131_fifo_read_stream.sv - non-showahead FIFO read port to valid/ready stream
// Two-entry skid buffer absorbs the one-cycle read latency so full throughput is kept.
module alt_vipcts131_fifo_read_stream #(
  parameter int DATA_WIDTH  = 20,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   fifo_rdempty,
  input  logic [DATA_WIDTH-1:0]  fifo_q,
  output logic                   fifo_rdreq,
  input  logic                   flush,
  output logic [DATA_WIDTH-1:0]  dout_data,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [1:0]             occupancy,
  output logic [COUNT_WIDTH-1:0] word_count
);

  logic [DATA_WIDTH-1:0]  buffer [2];
  logic                   head;
  logic                   tail;
  logic                   inflight;
  logic [1:0]             occ;
  logic [COUNT_WIDTH-1:0] count;
  logic                   pop;
  logic                   capture;
  logic [2:0]             space;

  // A slot freed by this cycle's pop may be refilled by this cycle's request.
  always_comb begin
    pop     = dout_valid & dout_ready;
    capture = inflight & ~flush;
    space   = 3'd2 + 3'(pop) - 3'(occ) - 3'(inflight);
  end

  assign dout_valid = (occ != 2'd0) & ~flush;
  assign dout_data  = (occ != 2'd0) ? buffer[head] : '0;
  assign fifo_rdreq = reset_n & ~fifo_rdempty & ~flush & (space != 3'd0);
  assign occupancy  = occ;
  assign word_count = count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buffer[0] <= '0;
      buffer[1] <= '0;
      head      <= 1'b0;
      tail      <= 1'b0;
      inflight  <= 1'b0;
      occ       <= 2'd0;
      count     <= '0;
    end else if (flush) begin
      head     <= 1'b0;
      tail     <= 1'b0;
      inflight <= 1'b0;
      occ      <= 2'd0;
    end else begin
      inflight <= fifo_rdreq;
      if (capture) begin
        buffer[tail] <= fifo_q;
        tail         <= ~tail;
      end
      if (pop) begin
        head  <= ~head;
        count <= count + COUNT_WIDTH'(1);
      end
      occ <= occ + 2'(capture) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_alt_vipcts131_fifo_read_stream.sv
// tb/tb_alt_vipcts131_fifo_read_stream.sv - bench for the FIFO read stream stage
// Queue-based FIFO source and skid-buffer model, per-cycle compare, directed scenarios.
module tb_alt_vipcts131_fifo_read_stream;
  localparam int DW = 20;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          fifo_rdempty = 1'b1;
  logic [DW-1:0] fifo_q = '0;
  logic          fifo_rdreq;
  logic          flush = 1'b0;
  logic [DW-1:0] dout_data;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic [1:0]    occupancy;
  logic [CW-1:0] word_count;

  alt_vipcts131_fifo_read_stream #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset_n(reset_n), .fifo_rdempty(fifo_rdempty), .fifo_q(fifo_q),
    .fifo_rdreq(fifo_rdreq), .flush(flush), .dout_data(dout_data), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .occupancy(occupancy), .word_count(word_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] mem[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] rx[$];
  int            rx_cyc[$];
  bit            m_inflight = 1'b0;
  logic [DW-1:0] m_inflight_word = '0;
  int unsigned   m_count = 0;
  int            cyc = 0;
  int            rdreq_cnt = 0;
  int            first_rd = -1;
  int            first_val = -1;
  bit            chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem.push_back(w);
    fifo_rdempty = 1'b0;
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_inflight = 1'b0;
    m_count = 0;
  endtask

  // One clock: sample before the edge, then advance the FIFO source and the model.
  task automatic tick();
    bit rd, pp, fl, vl;
    logic [DW-1:0] d;
    @(negedge clock);
    rd = fifo_rdreq;
    vl = dout_valid;
    pp = dout_valid & dout_ready;
    fl = flush;
    d  = dout_data;
    if (rd && first_rd < 0) first_rd = cyc;
    if (vl && first_val < 0) first_val = cyc;
    @(posedge clock);
    #1;
    if (!reset_n) begin
      model_clear();
    end else begin
      if (rd) rdreq_cnt++;
      if (pp) begin
        rx.push_back(d);
        rx_cyc.push_back(cyc);
        m_count++;
      end
      if (fl) begin
        exp_q.delete();
      end else begin
        if (pp && exp_q.size() != 0) void'(exp_q.pop_front());
        if (m_inflight) exp_q.push_back(m_inflight_word);
      end
      m_inflight = rd;
      if (rd && mem.size() != 0) begin
        fifo_q = mem.pop_front();
        m_inflight_word = fifo_q;
      end
    end
    fifo_rdempty = (mem.size() == 0);
    cyc++;
  endtask

  task automatic run_until_rx(input int n, input int budget, input string name);
    int k = 0;
    while (rx.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(name, rx.size(), n);
  endtask

  // Per-cycle compare against the queue model, plus a model-independent hold check.
  bit            prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;
  always @(negedge clock) begin : cmp
    int sz;
    int sp;
    if (!reset_n) begin
      prev_hold = 1'b0;
    end else if (chk_en) begin
      sz = exp_q.size();
      sp = 2 - sz - int'(m_inflight) + int'((sz != 0) && !flush && dout_ready);
      check("occupancy", occupancy, sz);
      check("occupancy_le_2", occupancy <= 2'd2, 1);
      check("dout_valid", dout_valid, (sz != 0) && !flush);
      check("dout_data", dout_data, (sz != 0) ? exp_q[0] : '0);
      check("word_count", word_count, m_count % 65536);
      check("fifo_rdreq", fifo_rdreq, !fifo_rdempty && !flush && (sp != 0));
      if (fifo_rdreq) check("rdreq_while_empty", fifo_rdempty, 0);
      if (prev_hold && !flush) begin
        check("hold_valid", dout_valid, 1);
        check("hold_data", dout_data, prev_data);
      end
      prev_hold = dout_valid && !dout_ready;
      prev_data = dout_data;
    end
  end

  initial begin
    int bad;
    int k;
    int n;
    logic [DW-1:0] w;

    // 1: reset values, latency after release, async reset mid-stream
    for (int i = 0; i < 4; i++) push(20'hA0001 + DW'(i));
    repeat (3) @(posedge clock);
    #1;
    check("reset_occupancy", occupancy, 0);
    check("reset_dout_valid", dout_valid, 0);
    check("reset_dout_data", dout_data, 0);
    check("reset_word_count", word_count, 0);
    check("reset_rdreq", fifo_rdreq, 0);
    reset_n = 1'b1;
    chk_en = 1'b1;
    k = 0;
    while (first_val < 0 && k < 10) begin tick(); k++; end
    check("first_rdreq_seen", first_rd >= 0, 1);
    check("latency_rdreq_to_valid", first_val - first_rd, 2);
    k = 0;
    while (exp_q.size() < 2 && k < 10) begin tick(); k++; end
    check("fill_occupancy", occupancy, 2);
    check("fill_data", dout_data, 20'hA0001);
    #1;
    reset_n = 1'b0;
    model_clear();
    #1;
    check("async_occupancy", occupancy, 0);
    check("async_dout_valid", dout_valid, 0);
    check("async_dout_data", dout_data, 0);
    check("async_word_count", word_count, 0);
    check("async_rdreq", fifo_rdreq, 0);
    tick();
    tick();
    mem.delete();

    // 2: streaming 64 words
    for (int i = 1; i <= 64; i++) push(DW'(i));
    dout_ready = 1'b1;
    rx.delete();
    rx_cyc.delete();
    reset_n = 1'b1;
    run_until_rx(64, 200, "stream_count");
    bad = 0;
    for (int i = 0; i < rx.size(); i++) if (rx[i] !== DW'(i + 1)) bad++;
    check("stream_order", bad, 0);
    if (rx.size() == 64) check("stream_no_bubbles", rx_cyc[63] - rx_cyc[0], 63);
    check("stream_word_count", word_count, 64);

    // 3: random backpressure over 1000 words
    rx.delete();
    rx_cyc.delete();
    for (int i = 0; i < 1000; i++) push(20'h10000 + DW'(i));
    k = 0;
    while (rx.size() < 1000 && k < 6000) begin
      dout_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    check("bp_count", rx.size(), 1000);
    bad = 0;
    for (int i = 0; i < rx.size(); i++) if (rx[i] !== 20'h10000 + DW'(i)) bad++;
    check("bp_order", bad, 0);
    check("bp_word_count", word_count, 1064);

    // 4: stall-fill then back-to-back drain
    dout_ready = 1'b0;
    tick();
    rdreq_cnt = 0;
    for (int i = 0; i < 5; i++) push(20'h20000 + DW'(i));
    repeat (10) tick();
    check("stall_rdreqs", rdreq_cnt, 2);
    check("stall_occupancy", occupancy, 2);
    rx.delete();
    rx_cyc.delete();
    dout_ready = 1'b1;
    run_until_rx(5, 20, "drain_count");
    bad = 0;
    for (int i = 0; i < rx.size(); i++) if (rx[i] !== 20'h20000 + DW'(i)) bad++;
    check("drain_order", bad, 0);
    if (rx.size() == 5) check("drain_back_to_back", rx_cyc[4] - rx_cyc[0], 4);

    // 5: flush with one word buffered and one in flight
    repeat (3) tick();
    rx.delete();
    for (int i = 0; i < 8; i++) push(20'h30000 + DW'(i));
    repeat (4) tick();
    check("preflush_occupancy", occupancy, 1);
    check("preflush_inflight_word", m_inflight_word, 20'h30003);
    check("preflush_word_count", word_count, 1071);
    flush = 1'b1;
    #1;
    check("flush_dout_valid", dout_valid, 0);
    check("flush_rdreq", fifo_rdreq, 0);
    tick();
    flush = 1'b0;
    #1;
    check("postflush_occupancy", occupancy, 0);
    check("postflush_dout_valid", dout_valid, 0);
    check("postflush_word_count", word_count, 1071);
    rx.delete();
    run_until_rx(4, 20, "postflush_count");
    if (rx.size() == 4) begin
      check("postflush_first", rx[0], 20'h30004);
      check("postflush_last", rx[3], 20'h30007);
    end

    // 6: single word then empty; word_count wrap
    repeat (3) tick();
    rdreq_cnt = 0;
    rx.delete();
    push(20'h40000);
    repeat (8) tick();
    check("single_rdreqs", rdreq_cnt, 1);
    check("single_transfers", rx.size(), 1);
    if (rx.size() == 1) check("single_data", rx[0], 20'h40000);
    check("single_rdreq_idle", fifo_rdreq, 0);
    check("single_word_count", word_count, 1076);
    n = 65535 - 1076;
    rx.delete();
    for (int i = 0; i < n; i++) begin
      w = DW'(i);
      push(w);
    end
    run_until_rx(n, n + 50, "wrap_fill_count");
    check("wrap_all_ones", word_count, 16'hFFFF);
    push(20'h55555);
    run_until_rx(n + 1, 20, "wrap_last_count");
    check("wrap_zero", word_count, 16'h0000);
    if (rx.size() == n + 1) check("wrap_last_data", rx[n], 20'h55555);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
